// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one VGA draw datapath among four sprite requesters.
// Define DRAW_ARB_TIMEOUT_EN to build the WAIT watchdog (TIMEOUT cycles, sticky timeout_err).
module draw_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  req,
   input  logic [7:0]  req_op,
   input  logic [31:0] req_x,
   input  logic [27:0] req_y,
   output logic [3:0]  gnt,
   output logic [3:0]  ack,
   output logic        draw_start,
   output logic [1:0]  draw_op,
   output logic [7:0]  draw_x,
   output logic [6:0]  draw_y,
   input  logic        draw_done,
   output logic        busy,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_ptr;
   logic [1:0]  r_idx;
   logic [3:0]  r_gnt;
   logic [1:0]  r_op;
   logic [7:0]  r_x;
   logic [6:0]  r_y;
   logic        w_selValid;
   logic [1:0]  w_selIdx;
   logic [1:0]  w_cand;
   logic [1:0]  w_selOp;
   logic [7:0]  w_selX;
   logic [6:0]  w_selY;
   logic        w_timeout;

   // Scan downward so the candidate closest to r_ptr is the last one written.
   always_comb begin
      w_selValid = 1'b0;
      w_selIdx   = r_ptr;
      w_cand     = r_ptr;
      for (int k = 3; k >= 0; k--) begin
         w_cand = r_ptr + 2'(k);
         if (req[w_cand]) begin
            w_selValid = 1'b1;
            w_selIdx   = w_cand;
         end
      end
   end

   always_comb begin
      w_selOp = req_op[1:0];
      w_selX  = req_x[7:0];
      w_selY  = req_y[6:0];
      case (w_selIdx)
         2'd0: begin
            w_selOp = req_op[1:0];
            w_selX  = req_x[7:0];
            w_selY  = req_y[6:0];
         end
         2'd1: begin
            w_selOp = req_op[3:2];
            w_selX  = req_x[15:8];
            w_selY  = req_y[13:7];
         end
         2'd2: begin
            w_selOp = req_op[5:4];
            w_selX  = req_x[23:16];
            w_selY  = req_y[20:14];
         end
         default: begin
            w_selOp = req_op[7:6];
            w_selX  = req_x[31:24];
            w_selY  = req_y[27:21];
         end
      endcase
   end

`ifdef DRAW_ARB_TIMEOUT_EN
   localparam int CntWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CntWidth-1:0] r_waitCnt;
   logic                r_err;

   // The counter idles at zero outside WAIT, so it is already clear on WAIT entry.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_waitCnt <= '0;
         r_err     <= 1'b0;
      end else begin
         if (r_state == WAIT) begin
            r_waitCnt <= r_waitCnt + 1'b1;
         end else begin
            r_waitCnt <= '0;
         end
         if (r_state == WAIT && w_timeout && !draw_done) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_timeout   = (r_waitCnt == CntWidth'(TIMEOUT - 1));
   assign timeout_err = r_err;
`else
   logic w_unusedTimeout;

   assign w_unusedTimeout = (TIMEOUT > 0);
   assign w_timeout       = 1'b0;
   assign timeout_err     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_selValid) begin
               w_next = START;
            end
         end
         START: begin
            w_next = WAIT;
         end
         WAIT: begin
            if (draw_done || w_timeout) begin
               w_next = ACK;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Operands are captured only on the IDLE->START edge, once per grant.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_ptr <= 2'd0;
         r_idx <= 2'd0;
         r_gnt <= 4'b0000;
         r_op  <= 2'd0;
         r_x   <= 8'd0;
         r_y   <= 7'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_selValid) begin
                  r_idx <= w_selIdx;
                  r_gnt <= 4'b0001 << w_selIdx;
                  r_op  <= w_selOp;
                  r_x   <= w_selX;
                  r_y   <= w_selY;
               end
            end
            ACK: begin
               r_gnt <= 4'b0000;
               r_ptr <= r_idx + 2'd1;
            end
            default: begin
               r_gnt <= r_gnt;
            end
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign ack        = (r_state == ACK) ? r_gnt : 4'b0000;
   assign draw_start = (r_state == START);
   assign busy       = (r_state != IDLE);
   assign draw_op    = r_op;
   assign draw_x     = r_x;
   assign draw_y     = r_y;

endmodule

// File: tb/tb_draw_arbiter.sv
// Self-checking bench for draw_arbiter: directed scenarios plus randomized draws
// checked against a round-robin reference model kept in the bench.
module tb_draw_arbiter;

   logic        clk;
   logic        reset_n;
   logic [3:0]  req;
   logic [7:0]  req_op;
   logic [31:0] req_x;
   logic [27:0] req_y;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic        draw_start;
   logic [1:0]  draw_op;
   logic [7:0]  draw_x;
   logic [6:0]  draw_y;
   logic        draw_done;
   logic        busy;
   logic        timeout_err;

   int vectors     = 0;
   int miscompares = 0;
   int mPtr        = 0;
   logic mErr      = 1'b0;

   draw_arbiter #(.TIMEOUT(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (req),
      .req_op      (req_op),
      .req_x       (req_x),
      .req_y       (req_y),
      .gnt         (gnt),
      .ack         (ack),
      .draw_start  (draw_start),
      .draw_op     (draw_op),
      .draw_x      (draw_x),
      .draw_y      (draw_y),
      .draw_done   (draw_done),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every comparison funnels through here so the counters stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference round-robin choice: first set request at or after ptr, wrapping.
   function automatic int pickIdx(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic randomOperands();
      for (int i = 0; i < 4; i++) begin
         req_op[2*i +: 2] = 2'($urandom_range(0, 2));
      end
      req_x = $urandom;
      req_y = 28'($urandom);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
      checkOutput({tag, "_ack"}, 32'(ack), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_start"}, 32'(draw_start), 32'd0);
      checkOutput({tag, "_terr"}, 32'(timeout_err), 32'(mErr));
   endtask

   // One full grant: present reqV in IDLE, complete the draw on WAIT cycle waitCycles.
   task automatic applyStimulus(input logic [3:0] reqV, input int waitCycles);
      int         idx;
      logic [3:0] eGnt;
      logic [1:0] eOp;
      logic [7:0] eX;
      logic [6:0] eY;
      idx  = pickIdx(reqV, mPtr);
      eGnt = 4'(1 << idx);
      eOp  = req_op[2*idx +: 2];
      eX   = req_x[8*idx +: 8];
      eY   = req_y[7*idx +: 7];
      req  = reqV;
      @(posedge clk); #1;
      checkOutput("start_gnt", 32'(gnt), 32'(eGnt));
      checkOutput("start_pulse", 32'(draw_start), 32'd1);
      checkOutput("start_op", 32'(draw_op), 32'(eOp));
      checkOutput("start_x", 32'(draw_x), 32'(eX));
      checkOutput("start_y", 32'(draw_y), 32'(eY));
      checkOutput("start_ack", 32'(ack), 32'd0);
      draw_done = 1'($urandom_range(0, 1));
      req = 4'($urandom);
      randomOperands();
      for (int c = 1; c <= waitCycles; c++) begin
         @(posedge clk); #1;
         checkOutput("wait_gnt", 32'(gnt), 32'(eGnt));
         checkOutput("wait_start", 32'(draw_start), 32'd0);
         checkOutput("wait_x", 32'(draw_x), 32'(eX));
         checkOutput("wait_y", 32'(draw_y), 32'(eY));
         checkOutput("wait_op", 32'(draw_op), 32'(eOp));
         checkOutput("wait_ack", 32'(ack), 32'd0);
         checkOutput("wait_busy", 32'(busy), 32'd1);
         req = 4'($urandom);
         randomOperands();
         draw_done = (c == waitCycles);
      end
      @(posedge clk); #1;
      checkOutput("ack_pulse", 32'(ack), 32'(eGnt));
      checkOutput("ack_x", 32'(draw_x), 32'(eX));
      checkOutput("ack_busy", 32'(busy), 32'd1);
      checkOutput("ack_terr", 32'(timeout_err), 32'(mErr));
      draw_done = 1'($urandom_range(0, 1));
      req = 4'b0000;
      @(posedge clk); #1;
      checkIdle("post_ack");
      draw_done = 1'b0;
      mPtr = (idx + 1) % 4;
   endtask

   initial begin
      reset_n   = 1'b0;
      req       = 4'b0000;
      req_op    = 8'd0;
      req_x     = 32'd0;
      req_y     = 28'd0;
      draw_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkIdle("reset");
      checkOutput("reset_op", 32'(draw_op), 32'd0);
      checkOutput("reset_x", 32'(draw_x), 32'd0);
      checkOutput("reset_y", 32'(draw_y), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      checkIdle("after_reset");

      // Ship draws at (82,100), done five WAIT cycles later.
      req_op = 8'd0;
      req_x  = 32'd82;
      req_y  = 28'd100;
      applyStimulus(4'b0001, 5);

      // All four held: expect 1,2,3,0,1 since the pointer now sits at 1.
      for (int n = 0; n < 5; n++) begin
         randomOperands();
         applyStimulus(4'b1111, 3);
      end

      // After a grant to requester 1, requester 0 wins over 1 via wrap-around.
      randomOperands();
      applyStimulus(4'b0010, 2);
      randomOperands();
      applyStimulus(4'b0011, 1);

      // Reset during WAIT, then a stale draw_done after release.
      req_x = 32'h5C5C_5C5C;
      req   = 4'b0100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("rst_wait_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      req     = 4'b0000;
      @(posedge clk); #1;
      mPtr = 0;
      mErr = 1'b0;
      checkIdle("rst_mid");
      checkOutput("rst_mid_x", 32'(draw_x), 32'd0);
      reset_n   = 1'b1;
      draw_done = 1'b1;
      @(posedge clk); #1;
      checkIdle("rst_stale_done");
      draw_done = 1'b0;
      @(posedge clk); #1;
      checkIdle("rst_settled");

`ifdef DRAW_ARB_TIMEOUT_EN
      // Done on the very cycle the watchdog expires counts as normal completion.
      randomOperands();
      applyStimulus(4'b1000, 16);
      begin
         int n;
         n = 0;
         randomOperands();
         req = 4'b0100;
         draw_done = 1'b0;
         @(posedge clk); #1;
         checkOutput("to_gnt", 32'(gnt), 32'(4'b0100));
         req = 4'b0000;
         while (ack == 4'b0000 && n < 64) begin
            @(posedge clk); #1;
            n++;
         end
         checkOutput("to_latency", 32'(n), 32'd17);
         checkOutput("to_ack", 32'(ack), 32'(4'b0100));
         checkOutput("to_err", 32'(timeout_err), 32'd1);
         mErr = 1'b1;
         mPtr = 3;
         @(posedge clk); #1;
         checkIdle("to_idle");
      end
`endif

      // Randomized draws against the reference model.
      for (int n = 0; n < 20; n++) begin
         randomOperands();
         applyStimulus(4'($urandom_range(1, 15)), int'($urandom_range(1, 8)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
